// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward/branch-select sequencer for the 5-stage pipeline with a debug halt/drain/step FSM.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] srcAdd1,
  input  logic [ADDR_W-1:0] srcAdd2,
  input  logic              useSrc2,
  input  logic [ADDR_W-1:0] destAddE,
  input  logic              RegWriteE,
  input  logic              MemToRegE,
  input  logic [ADDR_W-1:0] destAddM,
  input  logic              RegWriteM,
  input  logic              branchTakenD,
  input  logic              halt_req,
  input  logic              step,
  output logic              enF,
  output logic              enD,
  output logic              flushE,
  output logic              flushD,
  output logic              branchSel,
  output logic              forwardA,
  output logic              forwardB,
  output logic              halted
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [DCNT_W-1:0] dcnt_r;
  logic [DCNT_W-1:0] dcnt_s;
  logic              halted_r;
  logic              stall_s;
  logic              branch_ok_s;
  logic              m_a_s;
  logic              m_b_s;
  logic              haz_s;
  logic              branch_s;

  // Only an E-stage ALU result is forwarded; M-stage producers must wait for the W write.
  assign m_a_s = (srcAdd1 == destAddE);
  assign m_b_s = useSrc2 & (srcAdd2 == destAddE);
  assign haz_s = (RegWriteE & MemToRegE & (m_a_s | m_b_s)) |
                 (RegWriteM & ((srcAdd1 == destAddM) | (useSrc2 & (srcAdd2 == destAddM))));

  assign forwardA  = RegWriteE & ~MemToRegE & m_a_s;
  assign forwardB  = RegWriteE & ~MemToRegE & m_b_s;
  assign enF       = ~stall_s;
  assign enD       = ~stall_s;
  assign flushE    = stall_s;
  assign branch_s  = branchTakenD & ~haz_s & branch_ok_s;
  assign branchSel = branch_s;
  assign flushD    = branch_s;
  assign halted    = halted_r;

  // Next-state, drain count and stall decision.
  always_comb begin
    state_s     = state_r;
    dcnt_s      = dcnt_r;
    stall_s     = 1'b0;
    branch_ok_s = 1'b0;
    case (state_r)
      RUN: begin
        stall_s     = haz_s;
        branch_ok_s = 1'b1;
        if (halt_req) begin
          state_s = DRAIN;
          dcnt_s  = DCNT_W'(DRAIN_CYCLES);
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        stall_s = 1'b1;
        dcnt_s  = dcnt_r - DCNT_W'(1);
        // <= also catches a zero count so the drain can never wedge.
        if (dcnt_r <= DCNT_W'(1)) begin
          state_s = HALTED;
        end else begin
          state_s = DRAIN;
        end
      end
      HALTED: begin
        stall_s = 1'b1;
        if (!halt_req) begin
          state_s = RUN;
        end else if (step) begin
          state_s = STEP;
        end else begin
          state_s = HALTED;
        end
      end
      STEP: begin
        branch_ok_s = 1'b1;
        if (haz_s) begin
          stall_s = 1'b1;
          state_s = STEP;
        end else begin
          state_s = DRAIN;
          dcnt_s  = DCNT_W'(DRAIN_CYCLES);
        end
      end
      default: begin
        stall_s = 1'b0;
        state_s = RUN;
      end
    endcase
  end

  // State, drain counter and registered halted flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= RUN;
      dcnt_r   <= {DCNT_W{1'b0}};
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      dcnt_r   <= dcnt_s;
      halted_r <= (state_s == HALTED);
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counts of stalled-decode cycles and decode flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (!enD && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flushD && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule
